// File: rtl/exe_stage_mc.sv
// Execute stage: operand-2 shifter, single-cycle ALU, iterative shift-add MUL,
// branch target adder and the NZCV status register, behind a valid/ready input.
module exe_stage_mc #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned IMM_W  = 24,
    parameter bit          MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       EXE_CMD,
    input  logic             S,
    input  logic             imm,
    input  logic             MEM_R_EN,
    input  logic             MEM_W_EN,
    input  logic [3:0]       Dest,
    input  logic [WIDTH-1:0] PC,
    input  logic [WIDTH-1:0] Val_Rn,
    input  logic [WIDTH-1:0] Val_Rm,
    input  logic [11:0]      Shift_operand,
    input  logic [IMM_W-1:0] Signed_imm,
    output logic             out_valid,
    output logic [WIDTH-1:0] ALU_result,
    output logic [WIDTH-1:0] Br_addr,
    output logic [WIDTH-1:0] out_Val_Rm,
    output logic [3:0]       out_Dest,
    output logic             out_mem_r,
    output logic             out_mem_w,
    output logic [3:0]       status
);

    localparam int unsigned SUM_W = WIDTH + 1;
    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam int unsigned EXT_W = (WIDTH > IMM_W + 2) ? WIDTH : IMM_W + 2;

    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_MVN = 4'b1001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;
    localparam logic [3:0] CMD_MUL = 4'b1010;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d, acc_next;
    logic               mul_s_q, mul_s_d;
    logic               valid_q, valid_d;
    logic [WIDTH-1:0]   result_q, result_d, br_q, br_d, rm_q, rm_d;
    logic [3:0]         dest_q, dest_d, status_q, status_d;
    logic               memr_q, memr_d, memw_q, memw_d;

    logic [WIDTH-1:0]   val2, opb, alu_res, br_addr;
    logic [4:0]         sh_amt;
    logic [SUM_W-1:0]   sum;
    logic               sub_op, cin, arith, flag_en, is_mul;
    logic [3:0]         nzcv;

    function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] x, input int unsigned amt);
        int unsigned a;
        a = amt % WIDTH;
        return (x >> a) | (x << ((WIDTH - a) % WIDTH));
    endfunction

    // Operand 2: memory offset, rotated immediate or shifted register
    always_comb begin
        sh_amt = Shift_operand[11:7];
        val2   = WIDTH'(Shift_operand);
        if (!(MEM_R_EN || MEM_W_EN)) begin
            if (imm) begin
                val2 = rotr(WIDTH'(Shift_operand[7:0]), {27'd0, Shift_operand[11:8], 1'b0});
            end else if (sh_amt == 5'd0) begin
                val2 = Val_Rm;
            end else begin
                case (Shift_operand[6:5])
                    2'b00:   val2 = Val_Rm << sh_amt;
                    2'b01:   val2 = Val_Rm >> sh_amt;
                    2'b10:   val2 = $unsigned($signed(Val_Rm) >>> sh_amt);
                    default: val2 = rotr(Val_Rm, {27'd0, sh_amt});
                endcase
            end
        end
    end

    // Single-cycle ALU; subtraction reuses the adder with inverted operand 2
    always_comb begin
        sub_op  = (EXE_CMD == CMD_SUB) || (EXE_CMD == CMD_SBC);
        opb     = sub_op ? ~val2 : val2;
        cin     = (EXE_CMD == CMD_SUB) ||
                  (((EXE_CMD == CMD_ADC) || (EXE_CMD == CMD_SBC)) && status_q[1]);
        sum     = SUM_W'(Val_Rn) + SUM_W'(opb) + SUM_W'(cin);
        alu_res = '0;
        arith   = 1'b0;
        flag_en = 1'b1;
        case (EXE_CMD)
            CMD_MOV, CMD_MUL:                 alu_res = val2;
            CMD_MVN:                          alu_res = ~val2;
            CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: begin
                alu_res = sum[WIDTH-1:0];
                arith   = 1'b1;
            end
            CMD_AND:                          alu_res = Val_Rn & val2;
            CMD_ORR:                          alu_res = Val_Rn | val2;
            CMD_EOR:                          alu_res = Val_Rn ^ val2;
            default:                          flag_en = 1'b0;
        endcase
        nzcv = {alu_res[WIDTH-1], alu_res == '0,
                arith ? sum[WIDTH] : status_q[1],
                arith ? ((Val_Rn[WIDTH-1] == opb[WIDTH-1]) && (sum[WIDTH-1] != Val_Rn[WIDTH-1]))
                      : status_q[0]};
        is_mul  = MUL_EN && (EXE_CMD == CMD_MUL);
        br_addr = PC + WIDTH'({{(EXT_W - IMM_W){Signed_imm[IMM_W-1]}}, Signed_imm} << 2);
    end

    // Next-state: accept, MUL iteration/completion, flush override
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        mul_s_d  = mul_s_q;
        valid_d  = 1'b0;
        result_d = result_q;
        br_d     = br_q;
        rm_d     = rm_q;
        dest_d   = dest_q;
        memr_d   = memr_q;
        memw_d   = memw_q;
        status_d = status_q;
        acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
        if (flush) begin
            state_d = IDLE;
        end else if (state_q == IDLE) begin
            if (in_valid) begin
                br_d   = br_addr;
                rm_d   = Val_Rm;
                dest_d = Dest;
                memr_d = MEM_R_EN;
                memw_d = MEM_W_EN;
                if (is_mul) begin
                    state_d  = BUSY;
                    cnt_d    = '0;
                    acc_d    = '0;
                    mcand_d  = Val_Rn;
                    mplier_d = val2;
                    mul_s_d  = S;
                end else begin
                    valid_d  = 1'b1;
                    result_d = alu_res;
                    if (S && flag_en) status_d = nzcv;
                end
            end
        end else begin
            acc_d    = acc_next;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
                state_d  = IDLE;
                cnt_d    = '0;
                valid_d  = 1'b1;
                result_d = acc_next;
                if (mul_s_q) status_d = {acc_next[WIDTH-1], acc_next == '0, status_q[1:0]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            mul_s_q  <= 1'b0;
            valid_q  <= 1'b0;
            result_q <= '0;
            br_q     <= '0;
            rm_q     <= '0;
            dest_q   <= '0;
            memr_q   <= 1'b0;
            memw_q   <= 1'b0;
            status_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            mul_s_q  <= mul_s_d;
            valid_q  <= valid_d;
            result_q <= result_d;
            br_q     <= br_d;
            rm_q     <= rm_d;
            dest_q   <= dest_d;
            memr_q   <= memr_d;
            memw_q   <= memw_d;
            status_q <= status_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = valid_q;
    assign ALU_result = result_q;
    assign Br_addr    = br_q;
    assign out_Val_Rm = rm_q;
    assign out_Dest   = dest_q;
    assign out_mem_r  = memr_q;
    assign out_mem_w  = memw_q;
    assign status     = status_q;

endmodule

// File: tb/tb_exe_stage_mc.sv
// Bench for exe_stage_mc: directed vector table, MUL/flush/reset sequences,
// and random instructions against an arithmetic reference model.
module tb_exe_stage_mc;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready;
    logic [3:0]  EXE_CMD, Dest, out_Dest, status;
    logic        S, imm, MEM_R_EN, MEM_W_EN, out_valid, out_mem_r, out_mem_w;
    logic [31:0] PC, Val_Rn, Val_Rm, ALU_result, Br_addr, out_Val_Rm;
    logic [11:0] Shift_operand;
    logic [23:0] Signed_imm;

    int checks   = 0;
    int failures = 0;
    logic [3:0] m_status;

    localparam longint MAXS = 64'sd2147483647;
    localparam longint MINS = -64'sd2147483648;

    exe_stage_mc dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .EXE_CMD(EXE_CMD), .S(S), .imm(imm), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
        .Dest(Dest), .PC(PC), .Val_Rn(Val_Rn), .Val_Rm(Val_Rm),
        .Shift_operand(Shift_operand), .Signed_imm(Signed_imm),
        .out_valid(out_valid), .ALU_result(ALU_result), .Br_addr(Br_addr),
        .out_Val_Rm(out_Val_Rm), .out_Dest(out_Dest), .out_mem_r(out_mem_r),
        .out_mem_w(out_mem_w), .status(status)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [31:0] br;
        logic [3:0]  st;
        bit          mul;
    } exp_t;

    typedef struct {
        logic [3:0]  cmd;
        bit          s, im, mw;
        logic [31:0] pc, rn, rm;
        logic [11:0] sh;
        logic [23:0] simm;
        logic [31:0] res, br;
        logic [3:0]  st;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] cmd, input bit s, input bit im, input bit mr,
                         input bit mw, input logic [31:0] pc, input logic [31:0] rn,
                         input logic [31:0] rm, input logic [11:0] sh,
                         input logic [23:0] simm, input logic [3:0] dst);
        EXE_CMD = cmd; S = s; imm = im; MEM_R_EN = mr; MEM_W_EN = mw; PC = pc;
        Val_Rn = rn; Val_Rm = rm; Shift_operand = sh; Signed_imm = simm; Dest = dst;
        in_valid = 1'b1;
    endtask

    // Operand 2 built from repeated single-bit shift/rotate steps
    function automatic logic [31:0] m_val2(input bit im, input bit mr, input bit mw,
                                           input logic [31:0] rm, input logic [11:0] sh);
        logic [31:0] x;
        int amt;
        if (mr || mw) return 32'(sh);
        if (im) begin
            x = 32'(sh[7:0]);
            amt = 2 * int'(sh[11:8]);
            for (int i = 0; i < amt; i++) x = {x[0], x[31:1]};
            return x;
        end
        x = rm;
        amt = int'(sh[11:7]);
        for (int i = 0; i < amt; i++) begin
            case (sh[6:5])
                2'b00:   x = {x[30:0], 1'b0};
                2'b01:   x = {1'b0, x[31:1]};
                2'b10:   x = {x[31], x[31:1]};
                default: x = {x[0], x[31:1]};
            endcase
        end
        return x;
    endfunction

    function automatic exp_t model(input logic [3:0] cmd, input bit s, input bit im,
                                   input bit mr, input bit mw, input logic [31:0] pc,
                                   input logic [31:0] rn, input logic [31:0] rm,
                                   input logic [11:0] sh, input logic [23:0] simm,
                                   input logic [3:0] st);
        exp_t e;
        logic [31:0] v2, r;
        longint unsigned a, b, full, c, nc;
        longint sa, sb, ss, off;
        bit cout, ov, arith, known;
        v2 = m_val2(im, mr, mw, rm, sh);
        a = longint'(rn); b = longint'(v2);
        sa = longint'($signed(rn)); sb = longint'($signed(v2));
        c = longint'(st[1]); nc = 1 - c;
        r = '0; cout = 1'b0; ss = 0; arith = 1'b0; known = 1'b1;
        e.mul = 1'b0;
        case (cmd)
            4'h1: r = v2;
            4'h9: r = ~v2;
            4'h2: begin full = a + b; r = 32'(full); cout = full >= 64'h1_0000_0000; ss = sa + sb; arith = 1'b1; end
            4'h3: begin full = a + b + c; r = 32'(full); cout = full >= 64'h1_0000_0000; ss = sa + sb + longint'(c); arith = 1'b1; end
            4'h4: begin r = 32'(a - b); cout = a >= b; ss = sa - sb; arith = 1'b1; end
            4'h5: begin r = 32'(a - b - nc); cout = a >= b + nc; ss = sa - sb - longint'(nc); arith = 1'b1; end
            4'h6: r = rn & v2;
            4'h7: r = rn | v2;
            4'h8: r = rn ^ v2;
            4'hA: begin r = 32'(a * b); e.mul = 1'b1; end
            default: known = 1'b0;
        endcase
        ov = (ss > MAXS) || (ss < MINS);
        e.res = r;
        if (!s || !known) e.st = st;
        else if (arith)   e.st = {r[31], r == 32'd0, cout, ov};
        else              e.st = {r[31], r == 32'd0, st[1:0]};
        off = simm[23] ? longint'(simm) - 64'sd16777216 : longint'(simm);
        e.br = 32'(longint'(pc) + off * 4);
        return e;
    endfunction

    vec_t vt[21];

    initial begin
        exp_t e;
        int bad, lat, idx;
        logic [3:0] cmds [11];
        logic [3:0] cmd;
        bit mr, mw;
        cmds = '{4'h1, 4'h9, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'hA, 4'hC};

        vt[0]  = '{4'h2, 1, 0, 0, 32'h0,   32'h7FFFFFFF, 32'h1,        12'h0,   24'h0,      32'h80000000, 32'h0,   4'h9};
        vt[1]  = '{4'h3, 1, 0, 0, 32'h0,   32'hFFFFFFFF, 32'hFFFFFFFF, 12'h0,   24'h0,      32'hFFFFFFFE, 32'h0,   4'hA};
        vt[2]  = '{4'h0, 1, 0, 0, 32'h100, 32'h0,        32'h0,        12'h0,   24'hFFFFFF, 32'h0,        32'hFC,  4'hA};
        vt[3]  = '{4'h0, 0, 0, 0, 32'h100, 32'h0,        32'h0,        12'h0,   24'h000002, 32'h0,        32'h108, 4'hA};
        vt[4]  = '{4'h3, 1, 0, 0, 32'h0,   32'h0,        32'h0,        12'h0,   24'h0,      32'h1,        32'h0,   4'h0};
        vt[5]  = '{4'h1, 1, 1, 0, 32'h0,   32'h0,        32'h0,        12'h4FF, 24'h0,      32'hFF000000, 32'h0,   4'h8};
        vt[6]  = '{4'h1, 0, 0, 0, 32'h0,   32'h0,        32'h80000000, 12'h240, 24'h0,      32'hF8000000, 32'h0,   4'h8};
        vt[7]  = '{4'h2, 0, 0, 1, 32'h0,   32'h100,      32'h0,        12'hFFF, 24'h0,      32'h10FF,     32'h0,   4'h8};
        vt[8]  = '{4'h4, 1, 0, 0, 32'h0,   32'h5,        32'h5,        12'h0,   24'h0,      32'h0,        32'h0,   4'h6};
        vt[9]  = '{4'h5, 1, 0, 0, 32'h0,   32'h5,        32'h3,        12'h0,   24'h0,      32'h2,        32'h0,   4'h2};
        vt[10] = '{4'h4, 1, 0, 0, 32'h0,   32'h3,        32'h5,        12'h0,   24'h0,      32'hFFFFFFFE, 32'h0,   4'h8};
        vt[11] = '{4'h5, 1, 0, 0, 32'h0,   32'h3,        32'h2,        12'h0,   24'h0,      32'h0,        32'h0,   4'h6};
        vt[12] = '{4'h6, 1, 0, 0, 32'h0,   32'hF0F0,     32'h0FF0,     12'h0,   24'h0,      32'hF0,       32'h0,   4'h2};
        vt[13] = '{4'h7, 1, 0, 0, 32'h0,   32'h80000000, 32'h1,        12'h0,   24'h0,      32'h80000001, 32'h0,   4'hA};
        vt[14] = '{4'h8, 1, 0, 0, 32'h0,   32'hFFFF,     32'hFFFF,     12'h0,   24'h0,      32'h0,        32'h0,   4'h6};
        vt[15] = '{4'h9, 1, 0, 0, 32'h0,   32'h0,        32'h0,        12'h0,   24'h0,      32'hFFFFFFFF, 32'h0,   4'hA};
        vt[16] = '{4'h1, 0, 0, 0, 32'h0,   32'h0,        32'hF,        12'h200, 24'h0,      32'hF0,       32'h0,   4'hA};
        vt[17] = '{4'h1, 0, 0, 0, 32'h0,   32'h0,        32'hF0,       12'h220, 24'h0,      32'hF,        32'h0,   4'hA};
        vt[18] = '{4'h1, 0, 0, 0, 32'h0,   32'h0,        32'hAB,       12'h460, 24'h0,      32'hAB000000, 32'h0,   4'hA};
        vt[19] = '{4'h2, 1, 0, 0, 32'h0,   32'h80000000, 32'h80000000, 12'h0,   24'h0,      32'h0,        32'h0,   4'h7};
        vt[20] = '{4'hB, 1, 0, 0, 32'h0,   32'h5,        32'h5,        12'h0,   24'h0,      32'h0,        32'h0,   4'h7};

        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
        drive(4'h0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 12'h0, 24'h0, 4'h0);
        in_valid = 1'b0;
        #12;
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset result", ALU_result, 32'd0);
        chk("reset br", Br_addr, 32'd0);
        chk("reset rm", out_Val_Rm, 32'd0);
        chk("reset pass", {26'd0, out_Dest, out_mem_r, out_mem_w}, 32'd0);
        chk("reset status", 32'(status), 32'd0);
        tick();
        rst = 1'b1;
        tick();

        // Back-to-back vector table
        foreach (vt[i]) begin
            drive(vt[i].cmd, vt[i].s, vt[i].im, 1'b0, vt[i].mw, vt[i].pc, vt[i].rn,
                  vt[i].rm, vt[i].sh, vt[i].simm, 4'(i));
            tick();
            chk($sformatf("tbl%0d valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("tbl%0d result", i), ALU_result, vt[i].res);
            chk($sformatf("tbl%0d br", i), Br_addr, vt[i].br);
            chk($sformatf("tbl%0d status", i), 32'(status), 32'(vt[i].st));
        end

        // MUL 7x6 with a dependent ADC held during BUSY
        drive(4'hA, 1, 0, 0, 0, 32'h0, 32'd7, 32'd6, 12'h0, 24'h0, 4'h3);
        tick();
        chk("mul accept ready", 32'(in_ready), 32'd0);
        chk("mul accept valid", 32'(out_valid), 32'd0);
        drive(4'h3, 1, 0, 0, 0, 32'h0, 32'd1, 32'd1, 12'h0, 24'h0, 4'h4);
        bad = 0;
        for (int k = 1; k < 32; k++) begin
            tick();
            if (out_valid || in_ready) bad++;
        end
        chk("mul busy window", 32'(bad), 32'd0);
        tick();
        chk("mul done valid", 32'(out_valid), 32'd1);
        chk("mul done ready", 32'(in_ready), 32'd1);
        chk("mul result", ALU_result, 32'd42);
        chk("mul status", 32'(status), 32'h3);
        chk("mul dest", 32'(out_Dest), 32'h3);
        tick();
        in_valid = 1'b0;
        chk("held adc valid", 32'(out_valid), 32'd1);
        chk("held adc result", ALU_result, 32'd3);
        chk("held adc status", 32'(status), 32'h0);
        m_status = 4'h0;

        // Flush at MUL iteration 10
        drive(4'hA, 1, 0, 0, 0, 32'h0, 32'd0, 32'd5, 12'h0, 24'h0, 4'h1);
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush mul valid", 32'(out_valid), 32'd0);
        chk("flush mul ready", 32'(in_ready), 32'd1);
        chk("flush mul status", 32'(status), 32'(m_status));
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (out_valid) bad++;
        end
        chk("flush mul no late valid", 32'(bad), 32'd0);

        // Flush together with an ADD
        drive(4'h2, 1, 0, 0, 0, 32'h0, 32'd0, 32'd0, 12'h0, 24'h0, 4'h2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush add valid", 32'(out_valid), 32'd0);
        chk("flush add status", 32'(status), 32'(m_status));
        tick();
        chk("flush add after", 32'(out_valid), 32'd0);

        // Reset mid-MUL
        drive(4'h2, 1, 0, 0, 0, 32'h0, 32'h7FFFFFFF, 32'd1, 12'h0, 24'h0, 4'h0);
        tick();
        chk("pre-reset status", 32'(status), 32'h9);
        drive(4'hA, 1, 0, 0, 0, 32'h0, 32'd3, 32'd4, 12'h0, 24'h0, 4'h0);
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        rst = 1'b0;
        #1;
        chk("rst mid-mul ready", 32'(in_ready), 32'd1);
        chk("rst mid-mul valid", 32'(out_valid), 32'd0);
        chk("rst mid-mul status", 32'(status), 32'h0);
        tick();
        rst = 1'b1;
        tick();
        drive(4'h2, 1, 0, 0, 0, 32'h0, 32'd2, 32'd3, 12'h0, 24'h0, 4'h5);
        tick();
        in_valid = 1'b0;
        chk("post-reset valid", 32'(out_valid), 32'd1);
        chk("post-reset result", ALU_result, 32'd5);
        m_status = 4'h0;

        // Random instructions vs reference model
        for (int n = 0; n < 150; n++) begin
            idx = $urandom_range(0, 10);
            if (idx == 9 && $urandom_range(0, 3) != 0) idx = 2;
            cmd = cmds[idx];
            mr = ($urandom_range(0, 7) == 0);
            mw = !mr && ($urandom_range(0, 7) == 0);
            drive(cmd, 1'($urandom), 1'($urandom), mr, mw, $urandom, $urandom, $urandom,
                  12'($urandom), 24'($urandom), 4'($urandom));
            e = model(EXE_CMD, S, imm, MEM_R_EN, MEM_W_EN, PC, Val_Rn, Val_Rm,
                      Shift_operand, Signed_imm, m_status);
            tick();
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 40) begin
                tick();
                lat++;
            end
            chk($sformatf("rnd%0d latency", n), 32'(lat), e.mul ? 32'd33 : 32'd1);
            chk($sformatf("rnd%0d result", n), ALU_result, e.res);
            chk($sformatf("rnd%0d br", n), Br_addr, e.br);
            chk($sformatf("rnd%0d rm", n), out_Val_Rm, Val_Rm);
            chk($sformatf("rnd%0d pass", n), {26'd0, out_Dest, out_mem_r, out_mem_w},
                {26'd0, Dest, MEM_R_EN, MEM_W_EN});
            chk($sformatf("rnd%0d status", n), 32'(status), 32'(e.st));
            m_status = e.st;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/exe_stage_mc.md
# exe_stage_mc

Parametrised, registered execute stage for the pipelined ARM core. It sits between the ID/EXE and EXE/MEM pipeline registers and owns the NZCV status register. It generates the second operand (immediate rotate, register shift, memory offset), runs single-cycle ALU operations plus a multi-cycle iterative MUL, and computes the branch target. A valid/ready handshake on the input side stalls the upstream pipeline while a MUL is in flight.

## Interface
- WIDTH, 32, datapath width; must be ≥ 16.
- IMM_W, 24, width of the branch immediate field.
- MUL_EN, 1, 1 = MUL supported; 0 = EXE_CMD 1010 behaves as MOV.
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-low
- flush  in  1  discard the in-flight MUL and any instruction presented this cycle
- in_valid  in  1  instruction present on inputs
- in_ready  out  1  stage can accept an instruction
- EXE_CMD  in  4  operation code
- S  in  1  update status on commit
- imm  in  1  operand 2 is a rotated immediate
- MEM_R_EN, MEM_W_EN  in  1 each  load/store; passed through
- Dest  in  4  destination register; passed through
- PC  in  WIDTH  PC+4 of the instruction
- Val_Rn, Val_Rm  in  WIDTH  register operands
- Shift_operand  in  12  shifter field
- Signed_imm  in  IMM_W  branch offset in words
- out_valid  out  1  one-cycle pulse; registered outputs below are valid
- ALU_result, Br_addr, out_Val_Rm  out  WIDTH  registered results
- out_Dest  out  4; out_mem_r, out_mem_w  out  1 each  registered passthroughs
- status  out  4  NZCV register (N=bit3)

## Operation
- Operation codes: 0001 MOV, 1001 MVN, 0010 ADD (also LDR/STR), 0011 ADC, 0100 SUB/CMP, 0101 SBC, 0110 AND/TST, 0111 ORR, 1000 EOR, 1010 MUL. Other codes give result 0 and leave flags unchanged.
- Operand 2 (val2):
  - MEM_R_EN|MEM_W_EN: zero-extended Shift_operand[11:0].
  - Otherwise, imm=1: Shift_operand[7:0] zero-extended to WIDTH, rotated right by 2×Shift_operand[11:8].
  - Otherwise: Val_Rm shifted by Shift_operand[11:7], with the shift type in Shift_operand[6:5] (00 LSL, 01 LSR, 10 ASR, 11 ROR). A shift amount of 0 passes Val_Rm unchanged.
- Carry input for ADC/SBC is the C bit of the status register. SBC = Rn − val2 − !C.
- Flags:
  - N = result[WIDTH-1]; Z = (result==0).
  - Arithmetic ops set C as the carry out (subtraction: C = no borrow) and set V as two's-complement overflow.
  - Logic, move and MUL ops preserve C and V.
- Br_addr = PC + (sign_extend(Signed_imm) << 2), truncated to WIDTH.
- The status register is written on the commit edge only when S=1 and the instruction is not flushed.
- FSM states IDLE and BUSY; BUSY exists only if MUL_EN=1.
  - IDLE: in_ready=1. An accept (in_valid & in_ready & !flush) of a non-MUL op registers the results and sets out_valid=1 at the next edge.
  - IDLE → BUSY: an accepted MUL latches the operands, clears the accumulator and clears the counter.
  - BUSY: in_ready=0. Each edge performs one shift-add iteration and increments the counter.
  - BUSY → IDLE: on the WIDTH-th iteration edge, register the low WIDTH bits of the product, pulse out_valid and update status if S.
  - Any state, flush=1: state returns to IDLE; no out_valid and no status write at that edge.
- Flush has priority over accept and over MUL completion.

## Timing
- Reset (rst=0, asynchronous): state IDLE; in_ready=1; out_valid=0; ALU_result, Br_addr and out_Val_Rm = 0; out_Dest=0; out_mem_r and out_mem_w = 0; status=0000; counter=0. Reset mid-MUL abandons the MUL.
- Non-MUL latency: 1 edge from accept to out_valid.
- MUL latency: WIDTH edges from accept to out_valid. in_ready is low for WIDTH cycles following the accept edge.
- in_ready returns to 1 in the same cycle out_valid is high for the MUL, so a dependent ADC accepted that cycle sees the updated C.
- Back-to-back non-MUL accepts give out_valid high on consecutive cycles, with status updated on each edge.
- in_valid while in_ready=0 is ignored. Upstream must hold the instruction.

## Test plan
- Reset: assert rst=0 mid-MUL → in_ready=1, out_valid=0, status=0000 immediately; the next accept behaves normally.
- ADD, S=1: Rn=0x7FFFFFFF, Rm=1 → ALU_result=0x80000000, NZCV=1001. Then ADC with Rn=Rm=0xFFFFFFFF, S=1 → 0xFFFFFFFE, NZCV=1010. Then ADC with 0+0 → 0x00000001.
- Operand 2: imm=1, Shift_operand=0x4FF, MOV → 0xFF000000. Register ASR #4 (Shift_operand=0x240) of Rm=0x80000000 → 0xF8000000. STR with Shift_operand=0xFFF, Rn=0x100 → 0x10FF.
- Branch: PC=0x100, Signed_imm=0xFFFFFF → Br_addr=0xFC. Signed_imm=0x000002 → 0x108.
- MUL, S=1: 7×6 → in_ready low for 32 cycles, out_valid exactly 32 edges after accept with 42 and NZCV=00xx (C/V preserved). A held in_valid during BUSY is accepted only when in_ready returns.
- Flush: flush=1 at iteration 10 of a MUL → no out_valid, status unchanged, in_ready=1 next cycle. flush together with an in_valid ADD → nothing committed.
